// File: rtl/cpu_host_sequencer.sv
// Host sequencer: loads words into CPU data memory, runs the CPU until Halt/timeout, streams a memory range back.
// Latency: 2 cycles per load word, RUN lasts until Halt (from cycle 2) or TIMEOUT_CYCLES, 2 cycles per readback word.
// Backpressure: LoadReady only in IDLE; OUT holds the result stable and issues no new read until ResultReady.
module cpu_host_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd65536
) (
    input  logic        CLK,
    input  logic        Rst_n,
    input  logic        LoadValid,
    output logic        LoadReady,
    input  logic [31:0] LoadAddr,
    input  logic [31:0] LoadData,
    input  logic        LoadLast,
    input  logic [31:0] DumpBase,
    input  logic [15:0] DumpCount,
    output logic        ResultValid,
    input  logic        ResultReady,
    output logic [31:0] ResultAddr,
    output logic [31:0] ResultData,
    output logic        ResultLast,
    output logic        Busy,
    output logic        Done,
    output logic        TimedOut,
    output logic [31:0] CycleCount,
    output logic        Start,
    output logic        Stop,
    output logic        Verify,
    output logic [31:0] AddfromExtern,
    output logic [31:0] NumfromExtern,
    input  logic        Halt,
    input  logic [31:0] NumtoExtern
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_WR  = 3'd1,
        RUN      = 3'd2,
        READ_REQ = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t      state;
    logic        lastFlag;
    logic [31:0] dumpAddr;
    logic [15:0] remaining;

    logic [31:0] nextCount;
    logic        haltHit;
    logic        timeoutHit;

    // Halt is only meaningful once the CPU has been enabled for a full cycle;
    // a halt in the same cycle as the timeout takes precedence.
    assign nextCount  = CycleCount + 32'd1;
    assign haltHit    = Halt && (CycleCount != 32'd0);
    assign timeoutHit = (nextCount == TIMEOUT_CYCLES);

    // Session state machine; every output is a register updated here.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            lastFlag      <= 1'b0;
            dumpAddr      <= 32'd0;
            remaining     <= 16'd0;
            LoadReady     <= 1'b0;
            ResultValid   <= 1'b0;
            ResultAddr    <= 32'd0;
            ResultData    <= 32'd0;
            ResultLast    <= 1'b0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            TimedOut      <= 1'b0;
            CycleCount    <= 32'd0;
            Start         <= 1'b0;
            Stop          <= 1'b0;
            Verify        <= 1'b0;
            AddfromExtern <= 32'd0;
            NumfromExtern <= 32'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    LoadReady <= 1'b1;
                    if (LoadValid && LoadReady) begin
                        LoadReady     <= 1'b0;
                        Stop          <= 1'b1;
                        AddfromExtern <= LoadAddr & ~32'd3;
                        NumfromExtern <= LoadData;
                        TimedOut      <= 1'b0;
                        CycleCount    <= 32'd0;
                        Busy          <= 1'b1;
                        lastFlag      <= LoadLast;
                        if (LoadLast) begin
                            dumpAddr  <= DumpBase & ~32'd3;
                            remaining <= DumpCount;
                        end
                        state <= LOAD_WR;
                    end
                end
                LOAD_WR: begin
                    Stop <= 1'b0;
                    if (lastFlag) begin
                        Start <= 1'b1;
                        state <= RUN;
                    end else begin
                        LoadReady <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    CycleCount <= nextCount;
                    if (haltHit || timeoutHit) begin
                        Start    <= 1'b0;
                        lastFlag <= 1'b0;
                        if (!haltHit) begin
                            TimedOut <= 1'b1;
                        end
                        if (remaining != 16'd0) begin
                            Verify        <= 1'b1;
                            AddfromExtern <= dumpAddr;
                            state         <= READ_REQ;
                        end else begin
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                READ_REQ: begin
                    Verify      <= 1'b0;
                    ResultData  <= NumtoExtern;
                    ResultAddr  <= dumpAddr;
                    ResultLast  <= (remaining == 16'd1);
                    ResultValid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (ResultReady) begin
                        ResultValid <= 1'b0;
                        ResultLast  <= 1'b0;
                        dumpAddr    <= dumpAddr + 32'd4;
                        remaining   <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            Verify        <= 1'b1;
                            AddfromExtern <= dumpAddr + 32'd4;
                            state         <= READ_REQ;
                        end
                    end
                end
                DONE: begin
                    Busy      <= 1'b0;
                    LoadReady <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    Start     <= 1'b0;
                    Stop      <= 1'b0;
                    Verify    <= 1'b0;
                    Busy      <= 1'b0;
                    LoadReady <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
